// File: rtl/ft2232h_pkg.sv
// Shared types and defaults for the FT2232H synchronous-245 transmit path.
package ft2232h_pkg;

  localparam int USB_BYTE_W            = 8;
  localparam int FIFO_AW_DEF           = 4;
  localparam int FLUSH_IDLE_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    SIWU  = 2'd2
  } tx_state_e;

  // Bits needed to hold max_val (at least one).
  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) <= max_val) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ft2232h_tx_if.sv
// Byte push port plus FT2232H chip-side pins of the transmit controller.
interface ft2232h_tx_if
  import ft2232h_pkg::*;
#(
  parameter int FIFO_AW = FIFO_AW_DEF
);
  logic [USB_BYTE_W-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic                  flush_i;
  logic                  txe_ni;
  logic [USB_BYTE_W-1:0] data_o;
  logic                  wr_no;
  logic                  siwu_no;
  logic [FIFO_AW:0]      fifo_level_o;
  logic [31:0]           tx_count_o;
  logic                  busy_o;

  modport slave (
    input  tx_data_i, tx_valid_i, flush_i, txe_ni,
    output tx_ready_o, data_o, wr_no, siwu_no, fifo_level_o, tx_count_o, busy_o
  );

  modport master (
    output tx_data_i, tx_valid_i, flush_i, txe_ni,
    input  tx_ready_o, data_o, wr_no, siwu_no, fifo_level_o, tx_count_o, busy_o
  );
endinterface

// File: rtl/ft2232h_tx_fifo.sv
// Single-clock byte FIFO with registered level and a read-ahead head output.
module ft2232h_tx_fifo
  import ft2232h_pkg::*;
#(
  parameter int AW = FIFO_AW_DEF
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [USB_BYTE_W-1:0] din_i,
  output logic [USB_BYTE_W-1:0] head_o,
  output logic [AW:0]           level_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int DEPTH = 1 << AW;

  logic [USB_BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  push_s, pop_s;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];
  assign level_o = level_q;

  // Next pointer and occupancy values.
  always_comb begin
    wptr_d  = push_s ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_s ? rptr_q + AW'(1) : rptr_q;
    if (push_s && !pop_s) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      level_d = level_q - (AW+1)'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Pointer, level and storage registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      if (push_s) begin
        mem_q[wptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/ft2232h_tx.sv
// FT2232H sync-245 transmit controller: FIFO-buffered byte stream to WR#/data,
// TXE# flow control and SIWU# send-immediate (explicit or after idle timeout).
module ft2232h_tx
  import ft2232h_pkg::*;
#(
  parameter int FIFO_AW           = FIFO_AW_DEF,
  parameter int FLUSH_IDLE_CYCLES = FLUSH_IDLE_CYCLES_DEF
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  ft2232h_tx_if.slave  bus
);
  localparam int              IDLE_W   = cnt_w(FLUSH_IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_IDLE_CYCLES);
  localparam bit              AUTO_EN  = (FLUSH_IDLE_CYCLES != 0);

  tx_state_e             state_q, state_d;
  logic [USB_BYTE_W-1:0] data_q, data_d, head_s;
  logic                  wr_n_q, wr_n_d, siwu_n_q, siwu_n_d;
  logic [31:0]           tx_count_q, tx_count_d;
  logic                  flush_pending_q, flush_pending_d, dirty_q, dirty_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  push_s, pop_s, xfer_s, auto_flush_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [FIFO_AW:0]      level_s;

  ft2232h_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (bus.tx_data_i),
    .head_o  (head_s),
    .level_o (level_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // WR# low marks the output register valid, so a transfer is WRITE with TXE# low.
  assign push_s = bus.tx_valid_i && !fifo_full_s;
  assign xfer_s = (state_q == WRITE) && !bus.txe_ni;

  // Next-state, output register and flush bookkeeping.
  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    wr_n_d          = wr_n_q;
    siwu_n_d        = 1'b1;
    pop_s           = 1'b0;
    tx_count_d      = tx_count_q + 32'(xfer_s);
    dirty_d         = dirty_q || xfer_s;

    if (push_s || xfer_s) begin
      idle_cnt_d = '0;
    end else if ((state_q == IDLE) && fifo_empty_s && (idle_cnt_q != IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    // Raised on the edge the counter lands on the limit so SIWU# follows one cycle later.
    auto_flush_s    = AUTO_EN && dirty_q && (idle_cnt_d == IDLE_MAX);
    flush_pending_d = flush_pending_q || bus.flush_i || auto_flush_s;

    case (state_q)
      IDLE: begin
        if (!fifo_empty_s && !bus.txe_ni) begin
          pop_s   = 1'b1;
          data_d  = head_s;
          wr_n_d  = 1'b0;
          state_d = WRITE;
        end else if (flush_pending_q && fifo_empty_s) begin
          siwu_n_d = 1'b0;
          state_d  = SIWU;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (xfer_s) begin
          if (!fifo_empty_s) begin
            pop_s  = 1'b1;
            data_d = head_s;
          end else begin
            wr_n_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      SIWU: begin
        state_d         = IDLE;
        flush_pending_d = bus.flush_i;
        dirty_d         = 1'b0;
      end
      default: begin
        state_d = IDLE;
        wr_n_d  = 1'b1;
      end
    endcase
  end

  // State and registered chip-side outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      data_q          <= '0;
      wr_n_q          <= 1'b1;
      siwu_n_q        <= 1'b1;
      tx_count_q      <= '0;
      flush_pending_q <= 1'b0;
      dirty_q         <= 1'b0;
      idle_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      data_q          <= data_d;
      wr_n_q          <= wr_n_d;
      siwu_n_q        <= siwu_n_d;
      tx_count_q      <= tx_count_d;
      flush_pending_q <= flush_pending_d;
      dirty_q         <= dirty_d;
      idle_cnt_q      <= idle_cnt_d;
    end
  end

  assign bus.tx_ready_o   = !fifo_full_s;
  assign bus.data_o       = data_q;
  assign bus.wr_no        = wr_n_q;
  assign bus.siwu_no      = siwu_n_q;
  assign bus.fifo_level_o = level_s;
  assign bus.tx_count_o   = tx_count_q;
  assign bus.busy_o       = (state_q != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_ft2232h_tx.sv
// Bench for ft2232h_tx: directed timing scenarios plus a random phase scored
// against an in-order byte queue and conservation of accepted/transferred bytes.
module tb_ft2232h_tx;
  localparam int AW = 4;
  localparam int FIC = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [7:0] sb[$];
  int   accepted = 0;
  int   xfers = 0;

  always #5 clk = ~clk;

  ft2232h_tx_if #(.FIFO_AW(AW)) bus_if ();

  ft2232h_tx #(.FIFO_AW(AW), .FLUSH_IDLE_CYCLES(FIC)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic txe, input logic fl);
    bus_if.tx_valid_i = v;
    bus_if.tx_data_i  = d;
    bus_if.txe_ni     = txe;
    bus_if.flush_i    = fl;
  endtask

  task automatic clear_model();
    sb.delete();
    accepted = 0;
    xfers = 0;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    clear_model();
  endtask

  // Transaction monitor: inputs and outputs are stable at the falling edge and
  // describe what happens on the following rising edge.
  always @(negedge clk) begin
    if (rstn) begin
      chk("conserve", 32'(bus_if.fifo_level_o) + 32'(!bus_if.wr_no), 32'(accepted - xfers));
      if (!bus_if.wr_no && !bus_if.txe_ni) begin
        chk("xfer_avail", 32'(sb.size() > 0), 32'd1);
        chk("count", bus_if.tx_count_o, 32'(xfers));
        if (sb.size() > 0) chk("xfer_data", 32'(bus_if.data_o), 32'(sb.pop_front()));
        xfers++;
      end
      if (bus_if.tx_valid_i && bus_if.tx_ready_o) begin
        sb.push_back(bus_if.tx_data_i);
        accepted++;
      end
    end
  end

  initial begin
    logic [4:0] b_wr;
    logic [7:0] b_dat [5];
    int bi;
    logic rdy;
    b_wr  = 5'b10001;
    b_dat = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h33};

    // Reset values
    do_reset();
    chk("rst_wr", 32'(bus_if.wr_no), 32'd1);
    chk("rst_siwu", 32'(bus_if.siwu_no), 32'd1);
    chk("rst_data", 32'(bus_if.data_o), 32'h0);
    chk("rst_level", 32'(bus_if.fifo_level_o), 32'd0);
    chk("rst_ready", 32'(bus_if.tx_ready_o), 32'd1);
    chk("rst_count", bus_if.tx_count_o, 32'd0);
    chk("rst_busy", 32'(bus_if.busy_o), 32'd0);

    // Burst of three back-to-back pushes, edge k = N + k
    for (int k = 0; k < 5; k++) begin
      drive(k < 3, b_dat[(k < 3) ? k + 1 : 4], 1'b0, 1'b0);
      tick();
      chk("burst_wr", 32'(bus_if.wr_no), 32'(b_wr[k]));
      chk("burst_data", 32'(bus_if.data_o), 32'(b_dat[k]));
      chk("burst_count", bus_if.tx_count_o, (k < 2) ? 32'd0 : 32'(k - 1));
    end

    // Backpressure while 0xA1 is held
    do_reset();
    for (int k = 0; k < 13; k++) begin
      drive(k < 4, 8'hA0 + 8'(k), (k >= 3 && k <= 7), 1'b0);
      tick();
      if (k >= 3 && k <= 7) begin
        chk("bp_hold_data", 32'(bus_if.data_o), 32'hA1);
        chk("bp_hold_wr", 32'(bus_if.wr_no), 32'd0);
        chk("bp_hold_count", bus_if.tx_count_o, 32'd1);
      end
    end
    chk("bp_count", bus_if.tx_count_o, 32'd4);
    chk("bp_wr_idle", 32'(bus_if.wr_no), 32'd1);

    // Fill: one byte in the output register, sixteen in the FIFO
    do_reset();
    bi = 0;
    for (int k = 0; k < 20; k++) begin
      rdy = bus_if.tx_ready_o;
      drive(1'b1, 8'h40 + 8'(bi), (k >= 2), 1'b0);
      tick();
      if (rdy && bi < 17) bi++;
    end
    chk("full_level", 32'(bus_if.fifo_level_o), 32'd16);
    chk("full_ready", 32'(bus_if.tx_ready_o), 32'd0);
    chk("full_held", 32'(bus_if.data_o), 32'h40);
    chk("full_accepted", 32'(accepted), 32'd17);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (30) tick();
    chk("full_count", bus_if.tx_count_o, 32'd17);
    chk("full_drained", 32'(sb.size()), 32'd0);
    chk("full_level0", 32'(bus_if.fifo_level_o), 32'd0);

    // Explicit flush requested with the first of two pushes
    do_reset();
    for (int k = 0; k < 30; k++) begin
      drive(k < 2, 8'h5A + 8'(k), 1'b0, k == 0);
      tick();
      chk("flush_siwu", 32'(bus_if.siwu_no), (k == 4) ? 32'd0 : 32'd1);
      if (k == 4) chk("flush_wr_high", 32'(bus_if.wr_no), 32'd1);
    end

    // Auto-flush after FIC idle cycles, single pulse
    do_reset();
    for (int k = 0; k < 30; k++) begin
      drive(k == 0, 8'hC3, 1'b0, 1'b0);
      tick();
      if (k == 2) chk("auto_wr_rise", 32'(bus_if.wr_no), 32'd1);
      chk("auto_siwu", 32'(bus_if.siwu_no), (k == FIC + 3) ? 32'd0 : 32'd1);
    end

    // Asynchronous reset in the middle of a burst
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'h70 + 8'(k), 1'b0, 1'b0);
      tick();
    end
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(bus_if.wr_no), 32'd1);
    chk("mid_rst_data", 32'(bus_if.data_o), 32'h0);
    chk("mid_rst_level", 32'(bus_if.fifo_level_o), 32'd0);
    chk("mid_rst_count", bus_if.tx_count_o, 32'd0);
    chk("mid_rst_siwu", 32'(bus_if.siwu_no), 32'd1);
    chk("mid_rst_busy", 32'(bus_if.busy_o), 32'd0);
    do_reset();

    // Random traffic with random TXE# and flush requests
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 3,
            $urandom_range(0, 31) == 0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (40) tick();
    chk("rand_drained", 32'(sb.size()), 32'd0);
    chk("rand_count", bus_if.tx_count_o, 32'(xfers));
    chk("rand_level", 32'(bus_if.fifo_level_o), 32'd0);
    chk("rand_wr", 32'(bus_if.wr_no), 32'd1);
    chk("rand_busy", 32'(bus_if.busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ft2232h_tx.md
# ft2232h_tx

FPGA-side transmit controller for the FT2232H synchronous 245 FIFO interface, moving bytes from the FPGA to the USB host. Internal logic pushes bytes through a valid/ready port into a small single-clock FIFO. The block drives the chip's WR#, data bus and SIWU#, honouring TXE# flow control. It is the return path complementing the host-to-FPGA RX model. It runs on the chip's 60 MHz CLKOUT.

## Interface
Parameters:
- FIFO_AW, 4, FIFO address width; depth 2^FIFO_AW bytes
- FLUSH_IDLE_CYCLES, 64, idle cycles before auto send-immediate; 0 disables auto-flush

Ports:
- clk_i  in  1  FT2232H CLKOUT, the single clock
- rstn_i  in  1  reset, asynchronous, active-low
- tx_data_i  in  8  byte from internal logic
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  byte accepted on an edge where valid && ready
- flush_i  in  1  one-cycle request for a send-immediate
- txe_ni  in  1  chip TXE#; low = chip can accept data
- data_o  out  8  chip data bus (write direction)
- wr_no  out  1  chip WR#, registered
- siwu_no  out  1  chip SIWU#, registered
- fifo_level_o  out  FIFO_AW+1  FIFO occupancy, excluding the output register
- tx_count_o  out  32  bytes accepted by chip, wraps at 2^32
- busy_o  out  1  state != IDLE or FIFO non-empty

## Operation
- Push: tx_ready_o = !full, derived from the registered level only. When full, a same-cycle pop does not enable a push.
- A byte transfers to the chip on an edge where wr_no==0 && txe_ni==0. Each transfer increments tx_count_o.
- The output register holds one byte. wr_no==0 means the output register is valid.
- FSM states:
  - IDLE: wr_no=1. If FIFO non-empty && txe_ni==0, pop the head into data_o, set wr_no<=0, go to WRITE. Else if a flush is pending, go to SIWU.
  - WRITE, on an edge with txe_ni==0 (byte transferred):
    - if FIFO non-empty, pop the next byte into data_o and stay in WRITE;
    - else set wr_no<=1 and go to IDLE.
  - WRITE, on an edge with txe_ni==1: hold data_o, keep wr_no low, retry. No byte is lost or duplicated.
  - SIWU: siwu_no low for exactly one cycle, then IDLE. Clears flush_pending and dirty.
- flush_pending is set by flush_i, and is also set when idle_cnt reaches FLUSH_IDLE_CYCLES while dirty.
  - dirty is set on any transfer.
  - idle_cnt counts cycles in IDLE with the FIFO empty. It resets on any push or transfer and saturates.
- SIWU is entered only from IDLE with the FIFO empty. A flush requested mid-burst waits until the last byte transfers.
- flush_i asserted while flush_pending is already set merges into the one pending request.
- Reset values: wr_no=1, siwu_no=1, data_o=0x00, fifo_level_o=0, tx_count_o=0, busy_o=0, state=IDLE, flags and idle_cnt 0. tx_ready_o is 1 after reset.
- Reset asserted mid-burst: asynchronous return to reset values. FIFO contents and the held byte are discarded.

## Timing
- Push at edge N into an empty FIFO with txe_ni low: wr_no goes low after edge N+1, and the transfer occurs at edge N+2.
- Sustained throughput is 1 byte/cycle while txe_ni stays low and the FIFO stays non-empty.
- tx_count_o and fifo_level_o update on the same edge as the transfer or pop.
- The auto-flush siwu_no pulse starts FLUSH_IDLE_CYCLES+1 cycles after wr_no returns high, given no intervening push.

## Structure
- Package ft2232h_pkg:
  - FSM state enum {IDLE, WRITE, SIWU};
  - USB_BYTE_W=8;
  - default FIFO_AW;
  - default FLUSH_IDLE_CYCLES.
- Sub-module ft2232h_tx_fifo: single-clock FIFO with registered level, full/empty flags, and read-ahead head output. FSM, counters and output registers live in ft2232h_tx.

## Test plan
- Reset: hold rstn_i low, then release -> wr_no=1, siwu_no=1, data_o=0x00, fifo_level_o=0, tx_ready_o=1, tx_count_o=0.
- Burst: txe_ni=0, push 0x11,0x22,0x33 back-to-back from edge N -> wr_no low at edges N+2..N+4, data_o 0x11,0x22,0x33 in turn, tx_count_o=3, then wr_no=1.
- Backpressure: push 0xA0..0xA3, and raise txe_ni for 5 cycles while data_o=0xA1 -> data_o held at 0xA1, wr_no stays low, count frozen. After release, each byte transfers exactly once in order, tx_count_o=4.
- Full: txe_ni=1, offer 17 bytes -> first byte in output register, 16 in FIFO, fifo_level_o=16, tx_ready_o=0, 18th not accepted. Lower txe_ni -> 17 bytes delivered in order.
- Flush: push 2 bytes with flush_i on the first push -> a single one-cycle siwu_no pulse, only after the second transfer, with wr_no already high.
- Auto-flush and reset: FLUSH_IDLE_CYCLES=8, send one byte, then idle -> one siwu_no pulse 9 cycles after wr_no rises, no repeat. Asserting rstn_i mid-burst -> outputs immediately return to reset values, fifo_level_o=0.
